// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, result select, load extraction, retire counter (option: WB_SUBWORD_LOAD_EN)
module wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [2:0]            in_load_type,
    input  logic [1:0]            in_byte_off,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_data,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic                  wb_valid,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [31:0]           retire_count
);

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] result;
    logic              write_en;

`ifdef WB_SUBWORD_LOAD_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Little-endian sub-word extraction and sign/zero extension
    always_comb begin
        load_byte = in_mem_data[7:0];
        case (in_byte_off)
            2'd0: load_byte = in_mem_data[7:0];
            2'd1: load_byte = in_mem_data[15:8];
            2'd2: load_byte = in_mem_data[23:16];
            2'd3: load_byte = in_mem_data[31:24];
            default: load_byte = in_mem_data[7:0];
        endcase
        // Halfword alignment ignores the low offset bit
        load_half = in_byte_off[1] ? in_mem_data[31:16] : in_mem_data[15:0];
        load_data = in_mem_data;
        case (in_load_type)
            3'b001:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b010:  load_data = {24'd0, load_byte};
            3'b011:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {16'd0, load_half};
            default: load_data = in_mem_data;
        endcase
    end
`else
    logic unused_load_fields;

    assign load_data          = in_mem_data;
    assign unused_load_fields = ^{in_load_type, in_byte_off};
`endif

    assign result   = in_mem_to_reg ? load_data : in_alu_result;
    // Writes to $zero are dropped here, but the instruction still retires
    assign write_en = in_valid & in_reg_write & (in_write_reg != '0);

    // MEM/WB register: reset > flush > stall > capture; invalid input loads a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write    <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            wb_valid     <= 1'b0;
            retire_count <= 32'd0;
        end else if (flush || (!stall && !in_valid)) begin
            reg_write    <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            wb_valid     <= 1'b0;
        end else if (!stall) begin
            reg_write    <= write_en;
            write_reg    <= in_write_reg;
            write_data   <= result;
            wb_valid     <= 1'b1;
            retire_count <= retire_count + 32'd1;
        end
    end

    assign fwd_valid = reg_write;
    assign fwd_reg   = write_reg;
    assign fwd_data  = write_data;

endmodule
